// File: rtl/dynode_energy_int_pkg.sv
// Shared definitions for the dynode energy integrator: FSM encodings and
// fixed-point constants for the baseline and the energy output word.
package dynode_energy_int_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_INTEG = 3'd2,
        ST_CALC  = 3'd3,
        ST_OUT   = 3'd4
    } state_e;

    localparam int BL_FRAC   = 8;   // baseline is 8.8 fixed point
    localparam int ENE_SHIFT = 6;   // 8 fractional bits down to 2
    localparam int ACC_W     = 22;
    localparam int DIFF_W    = ACC_W + 1;

endpackage

// File: rtl/dynode_ene_mac.sv
// Window accumulator plus the len*baseline subtract; negative results
// clamp to zero so the energy word never wraps.
module dynode_ene_mac
    import dynode_energy_int_pkg::*;
#(
    parameter int LEN_W = 6,
    parameter int ENE_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [15:0]      curval_i,
    input  logic [LEN_W-1:0] intlen_i,
    input  logic             acc_en_i,
    input  logic [7:0]       adc_i,
    input  logic             calc_i,
    output logic [LEN_W-1:0] len_o,
    output logic [ENE_W-1:0] energy_o
);

    logic [LEN_W-1:0]  len_q;
    logic [15:0]       bl_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  prod;
    logic [DIFF_W-1:0] diff;
    logic [ENE_W-1:0]  energy_q, energy_d;

    always_comb begin
        prod     = ACC_W'(len_q) * ACC_W'(bl_q);
        diff     = {1'b0, acc_q} - {1'b0, prod};
        energy_d = diff[DIFF_W-1] ? '0 : ENE_W'(diff[DIFF_W-2:0] >> ENE_SHIFT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q    <= '0;
            bl_q     <= '0;
            acc_q    <= '0;
            energy_q <= '0;
        end else begin
            if (start_i) begin
                // a zero-length window is treated as one sample
                len_q <= (intlen_i == '0) ? LEN_W'(1) : intlen_i;
                bl_q  <= curval_i;
                acc_q <= '0;
            end else if (acc_en_i) begin
                acc_q <= acc_q + ACC_W'({adc_i, {BL_FRAC{1'b0}}});
            end
            if (calc_i)
                energy_q <= energy_d;
        end
    end

    assign len_o    = len_q;
    assign energy_o = energy_q;

endmodule

// File: rtl/dynode_energy_int.sv
// Dynode energy integrator: edge-triggered window, baseline correction and
// valid/ack output. DYN_ENE_TSTAMP_EN adds a latched 16-bit timestamp port.
module dynode_energy_int
    import dynode_energy_int_pkg::*;
#(
    parameter int LEN_W  = 6,
    parameter int PREDLY = 2,
    parameter int ENE_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dyn_event,
    input  logic             dyn_pileup,
    input  logic             dyn_pudump,
    input  logic [7:0]       dyn_adcdly,
    input  logic [15:0]      dyn_curval,
    input  logic [LEN_W-1:0] intlen,
    input  logic             ene_ack,
    output logic [ENE_W-1:0] dyn_energy,
    output logic             ene_valid,
    output logic             ene_pileup,
    output logic             ene_busy,
    output logic [7:0]       drop_cnt
`ifdef DYN_ENE_TSTAMP_EN
    ,
    output logic [15:0]      dyn_ene_tstamp
`endif
);

    localparam int CNT_W = (LEN_W > 4) ? LEN_W : 4;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             event_d_q, evt_start_q;
    logic             pileup_q, pileup_d;
    logic [7:0]       drop_q, drop_d;
    logic [8:0]       drop_sum;
    logic [1:0]       drop_inc;
    logic             start, acc_en, calc, abort, drop;
    logic [LEN_W-1:0] len_lat;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + 1'b1;
        start   = 1'b0;
        acc_en  = 1'b0;
        calc    = 1'b0;
        abort   = 1'b0;
        drop    = evt_start_q && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: if (evt_start_q) begin
                start   = 1'b1;
                cnt_d   = '0;
                state_d = (PREDLY == 0) ? ST_INTEG : ST_WAIT;
            end
            ST_WAIT: begin
                if (dyn_pudump) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_inc == CNT_W'(PREDLY)) begin
                    cnt_d   = '0;
                    state_d = ST_INTEG;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_INTEG: begin
                if (dyn_pudump) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    acc_en = 1'b1;
                    cnt_d  = cnt_inc;
                    if (cnt_inc == CNT_W'(len_lat))
                        state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                calc    = 1'b1;
                state_d = ST_OUT;
            end
            ST_OUT: if (ene_ack) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        pileup_d = pileup_q;
        if (start)
            pileup_d = 1'b0;
        else if (dyn_pileup && (state_q == ST_WAIT || state_q == ST_INTEG))
            pileup_d = 1'b1;

        // abort and drop can coincide, so the increment may be two
        drop_inc = {1'b0, abort} + {1'b0, drop};
        drop_sum = {1'b0, drop_q} + {7'b0, drop_inc};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            event_d_q   <= 1'b0;
            evt_start_q <= 1'b0;
            pileup_q    <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            event_d_q   <= dyn_event;
            evt_start_q <= dyn_event & ~event_d_q;
            pileup_q    <= pileup_d;
            drop_q      <= drop_d;
        end
    end

    dynode_ene_mac #(.LEN_W(LEN_W), .ENE_W(ENE_W)) u_mac (
        .clk      (clk),
        .rst      (reset),
        .start_i  (start),
        .curval_i (dyn_curval),
        .intlen_i (intlen),
        .acc_en_i (acc_en),
        .adc_i    (dyn_adcdly),
        .calc_i   (calc),
        .len_o    (len_lat),
        .energy_o (dyn_energy)
    );

`ifdef DYN_ENE_TSTAMP_EN
    logic [15:0] ts_q, ts_lat_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q     <= '0;
            ts_lat_q <= '0;
        end else begin
            ts_q <= ts_q + 16'd1;
            if (start)
                ts_lat_q <= ts_q;
        end
    end
    assign dyn_ene_tstamp = ts_lat_q;
`endif

    assign ene_valid  = (state_q == ST_OUT);
    assign ene_busy   = (state_q == ST_WAIT) || (state_q == ST_INTEG) || (state_q == ST_CALC);
    assign ene_pileup = pileup_q;
    assign drop_cnt   = drop_q;

endmodule
